// File: rtl/jedro_1_alu_arb_pkg.sv
// Shared constants for the jedro_1 ALU and its two-port arbiter: widths, op encodings, FSM states.
package jedro_1_alu_arb_pkg;

    localparam int unsigned DATA_WIDTH    = 32;
    localparam int unsigned OP_WIDTH      = 4;
    localparam int unsigned ARB_NUM_PORTS = 2;
    localparam int unsigned SHAMT_WIDTH   = 5;

    localparam logic [OP_WIDTH-1:0] ALU_OP_ADD  = 4'b0000;
    localparam logic [OP_WIDTH-1:0] ALU_OP_SLL  = 4'b0001;
    localparam logic [OP_WIDTH-1:0] ALU_OP_SLT  = 4'b0010;
    localparam logic [OP_WIDTH-1:0] ALU_OP_SLTU = 4'b0011;
    localparam logic [OP_WIDTH-1:0] ALU_OP_XOR  = 4'b0100;
    localparam logic [OP_WIDTH-1:0] ALU_OP_SRL  = 4'b0101;
    localparam logic [OP_WIDTH-1:0] ALU_OP_OR   = 4'b0110;
    localparam logic [OP_WIDTH-1:0] ALU_OP_AND  = 4'b0111;
    localparam logic [OP_WIDTH-1:0] ALU_OP_SUB  = 4'b1000;
    localparam logic [OP_WIDTH-1:0] ALU_OP_SRA  = 4'b1101;

    typedef enum logic [1:0] {
        ARB_ST_IDLE = 2'd0,
        ARB_ST_EXEC = 2'd1,
        ARB_ST_RESP = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [OP_WIDTH-1:0]   op;
        logic [DATA_WIDTH-1:0] opa;
        logic [DATA_WIDTH-1:0] opb;
    } alu_req_t;

endpackage

// File: rtl/jedro_1_alu.sv
// Combinational jedro_1 ALU; clock and reset exist only for interface compatibility.
module jedro_1_alu
    import jedro_1_alu_arb_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [OP_WIDTH-1:0]   alu_op_i,
    input  logic [DATA_WIDTH-1:0] alu_opa_i,
    input  logic [DATA_WIDTH-1:0] alu_opb_i,
    output logic [DATA_WIDTH-1:0] alu_res_o
);

    logic                   unused_ports;
    logic [SHAMT_WIDTH-1:0] shamt;

    assign unused_ports = &{1'b0, clk_i, rstn_i};
    assign shamt        = alu_opb_i[SHAMT_WIDTH-1:0];

    // Undecoded op selects return zero.
    always_comb begin
        alu_res_o = '0;
        case (alu_op_i)
            ALU_OP_ADD:  alu_res_o = alu_opa_i + alu_opb_i;
            ALU_OP_SUB:  alu_res_o = alu_opa_i - alu_opb_i;
            ALU_OP_SLL:  alu_res_o = alu_opa_i << shamt;
            ALU_OP_SRL:  alu_res_o = alu_opa_i >> shamt;
            ALU_OP_SRA:  alu_res_o = DATA_WIDTH'($signed(alu_opa_i) >>> shamt);
            ALU_OP_SLT:  alu_res_o = DATA_WIDTH'($signed(alu_opa_i) < $signed(alu_opb_i));
            ALU_OP_SLTU: alu_res_o = DATA_WIDTH'(alu_opa_i < alu_opb_i);
            ALU_OP_XOR:  alu_res_o = alu_opa_i ^ alu_opb_i;
            ALU_OP_OR:   alu_res_o = alu_opa_i | alu_opb_i;
            ALU_OP_AND:  alu_res_o = alu_opa_i & alu_opb_i;
            default:     alu_res_o = '0;
        endcase
    end

endmodule

// File: rtl/jedro_1_alu_arb.sv
// Round-robin two-port arbiter sharing one jedro_1_alu, one operation in flight.
// Optional per-port grant counters enabled by JEDRO_1_ALU_ARB_STATS_EN.
module jedro_1_alu_arb
    import jedro_1_alu_arb_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [ARB_NUM_PORTS-1:0] req_valid_i,
    output logic [ARB_NUM_PORTS-1:0] req_ready_o,
    input  logic [OP_WIDTH-1:0]      req_op0_i,
    input  logic [OP_WIDTH-1:0]      req_op1_i,
    input  logic [DATA_WIDTH-1:0]    req_opa0_i,
    input  logic [DATA_WIDTH-1:0]    req_opa1_i,
    input  logic [DATA_WIDTH-1:0]    req_opb0_i,
    input  logic [DATA_WIDTH-1:0]    req_opb1_i,
    output logic [ARB_NUM_PORTS-1:0] rsp_valid_o,
    input  logic [ARB_NUM_PORTS-1:0] rsp_ready_i,
    output logic [DATA_WIDTH-1:0]    rsp_data_o,
`ifdef JEDRO_1_ALU_ARB_STATS_EN
    output logic [31:0]              grant_cnt0_o,
    output logic [31:0]              grant_cnt1_o,
`endif
    output logic                     busy_o
);

    arb_state_e            state;
    arb_state_e            state_next;
    logic                  rr_last;
    logic                  grant;
    logic                  winner;
    logic                  accept;
    alu_req_t              req_sel;
    alu_req_t              req_q;
    logic [DATA_WIDTH-1:0] alu_res;

    // Single requester wins outright; on a tie the port not served last wins.
    always_comb begin
        state_next  = state;
        req_ready_o = '0;
        accept      = 1'b0;
        winner      = (req_valid_i == 2'b10) || ((&req_valid_i) && !rr_last);
        req_sel     = winner ? '{op: req_op1_i, opa: req_opa1_i, opb: req_opb1_i}
                             : '{op: req_op0_i, opa: req_opa0_i, opb: req_opb0_i};
        case (state)
            ARB_ST_IDLE: begin
                if (|req_valid_i) begin
                    req_ready_o = winner ? 2'b10 : 2'b01;
                    accept      = 1'b1;
                    state_next  = ARB_ST_EXEC;
                end
            end
            ARB_ST_EXEC: state_next = ARB_ST_RESP;
            ARB_ST_RESP: begin
                if (rsp_ready_i[grant]) begin
                    state_next = ARB_ST_IDLE;
                end
            end
            default: state_next = ARB_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ARB_ST_IDLE;
            rr_last     <= 1'b1;
            grant       <= 1'b0;
            req_q       <= '0;
            rsp_valid_o <= '0;
            rsp_data_o  <= '0;
            busy_o      <= 1'b0;
        end else begin
            state  <= state_next;
            busy_o <= (state_next != ARB_ST_IDLE);
            if (accept) begin
                req_q   <= req_sel;
                grant   <= winner;
                rr_last <= winner;
            end
            // Result is captured at the end of EXEC and held until the grantee accepts it.
            if (state == ARB_ST_EXEC) begin
                rsp_data_o  <= alu_res;
                rsp_valid_o <= grant ? 2'b10 : 2'b01;
            end else if ((state == ARB_ST_RESP) && (state_next == ARB_ST_IDLE)) begin
                rsp_valid_o <= '0;
            end
        end
    end

`ifdef JEDRO_1_ALU_ARB_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            grant_cnt0_o <= '0;
            grant_cnt1_o <= '0;
        end else if (accept) begin
            if (winner) begin
                grant_cnt1_o <= grant_cnt1_o + 32'd1;
            end else begin
                grant_cnt0_o <= grant_cnt0_o + 32'd1;
            end
        end
    end
`endif

    jedro_1_alu u_alu (
        .clk_i     (clk_i),
        .rstn_i    (~rst_i),
        .alu_op_i  (req_q.op),
        .alu_opa_i (req_q.opa),
        .alu_opb_i (req_q.opb),
        .alu_res_o (alu_res)
    );

endmodule

// File: tb/tb_jedro_1_alu_arb.sv
// Scoreboard bench for jedro_1_alu_arb: directed requests push expected responses, a monitor pops on handshake.
module tb_jedro_1_alu_arb;
    import jedro_1_alu_arb_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_i;
    logic [1:0]            req_valid_i;
    logic [1:0]            req_ready_o;
    logic [OP_WIDTH-1:0]   req_op0_i, req_op1_i;
    logic [DATA_WIDTH-1:0] req_opa0_i, req_opa1_i, req_opb0_i, req_opb1_i;
    logic [1:0]            rsp_valid_o;
    logic [1:0]            rsp_ready_i;
    logic [DATA_WIDTH-1:0] rsp_data_o;
    logic                  busy_o;
`ifdef JEDRO_1_ALU_ARB_STATS_EN
    logic [31:0]           grant_cnt0_o, grant_cnt1_o;
`endif

    always #5 clk = ~clk;

    jedro_1_alu_arb dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_op0_i   (req_op0_i),
        .req_op1_i   (req_op1_i),
        .req_opa0_i  (req_opa0_i),
        .req_opa1_i  (req_opa1_i),
        .req_opb0_i  (req_opb0_i),
        .req_opb1_i  (req_opb1_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
`ifdef JEDRO_1_ALU_ARB_STATS_EN
        .grant_cnt0_o(grant_cnt0_o),
        .grant_cnt1_o(grant_cnt1_o),
`endif
        .busy_o      (busy_o)
    );

    typedef struct packed {
        logic        port;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic void check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endfunction

    function automatic void push_exp(input logic port, input logic [31:0] data);
        exp_t e;
        e.port = port;
        e.data = data;
        exp_q.push_back(e);
    endfunction

    // Monitor: every response handshake must match the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_i && (|(rsp_valid_o & rsp_ready_i))) begin
            if (exp_q.size() == 0) begin
                check32("rsp_unexpected", 32'(rsp_valid_o), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check32("rsp_port", 32'(rsp_valid_o), e.port ? 32'd2 : 32'd1);
                check32("rsp_data", rsp_data_o, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (p == 0) begin
            req_op0_i = op; req_opa0_i = a; req_opb0_i = b; req_valid_i[0] = 1'b1;
        end else begin
            req_op1_i = op; req_opa1_i = a; req_opb1_i = b; req_valid_i[1] = 1'b1;
        end
    endtask

    // Returns at the negedge of the cycle in which port p sees ready.
    task automatic wait_accept(input int p);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (req_ready_o[p]) return;
        end
        check32("accept_timeout", 32'(req_ready_o), 32'(2'b01 << p));
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (!busy_o) return;
        end
        check32("idle_timeout", 32'(busy_o), 32'd0);
    endtask

    task automatic run_op(input int p, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        set_req(p, op, a, b);
        wait_accept(p);
        push_exp(p[0], exp);
        tick();
        req_valid_i[p] = 1'b0;
        wait_idle();
    endtask

    task automatic pulse_reset();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        int got;
        int last_c;
        rst_i       = 1'b1;
        req_valid_i = '0;
        rsp_ready_i = '0;
        req_op0_i = '0; req_op1_i = '0;
        req_opa0_i = '0; req_opa1_i = '0; req_opb0_i = '0; req_opb1_i = '0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;

        @(negedge clk);
        check32("reset_req_ready", 32'(req_ready_o), 32'd0);
        check32("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check32("reset_rsp_data", rsp_data_o, 32'd0);
        check32("reset_busy", 32'(busy_o), 32'd0);

        // Port 0 ADD, cycle-exact latency.
        tick();
        rsp_ready_i = 2'b11;
        set_req(0, ALU_OP_ADD, 32'd5, 32'd7);
        @(negedge clk);
        check32("t1_ready_c0", 32'(req_ready_o), 32'd1);
        push_exp(1'b0, 32'd12);
        tick();
        req_valid_i = '0;
        @(negedge clk);
        check32("t1_busy_c1", 32'(busy_o), 32'd1);
        check32("t1_rsp_valid_c1", 32'(rsp_valid_o), 32'd0);
        @(negedge clk);
        check32("t1_rsp_valid_c2", 32'(rsp_valid_o), 32'd1);
        check32("t1_rsp_data_c2", rsp_data_o, 32'd12);
        wait_idle();

        // Port 1 SUB wraps modulo 2^32.
        tick();
        run_op(1, ALU_OP_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE);

        // Both continuously valid: alternate 0,1,0,1 every 3 cycles.
        pulse_reset();
        set_req(0, ALU_OP_SRA, 32'h8000_0000, 32'd4);
        set_req(1, ALU_OP_XOR, 32'h0000_00FF, 32'h0000_000F);
        push_exp(1'b0, 32'hF800_0000);
        push_exp(1'b1, 32'h0000_00F0);
        push_exp(1'b0, 32'hF800_0000);
        push_exp(1'b1, 32'h0000_00F0);
        got    = 0;
        last_c = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            if (|(req_ready_o & req_valid_i)) begin
                check32("t3_grant", 32'(req_ready_o), (got % 2 == 1) ? 32'd2 : 32'd1);
                if (got > 0) check32("t3_gap", 32'(c - last_c), 32'd3);
                last_c = c;
                got++;
            end
        end
        check32("t3_grant_count", 32'(got), 32'd4);
        tick();
        req_valid_i = '0;
        wait_idle();

        // Back-pressure: result held, port 1 blocked, non-granted rsp_ready ignored.
        tick();
        rsp_ready_i = 2'b10;
        set_req(0, ALU_OP_SLT, 32'hFFFF_FFFF, 32'd1);
        wait_accept(0);
        push_exp(1'b0, 32'd1);
        tick();
        req_valid_i[0] = 1'b0;
        set_req(1, ALU_OP_XOR, 32'h0000_00FF, 32'h0000_000F);
        push_exp(1'b1, 32'h0000_00F0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid_o != 2'b00) break;
        end
        for (int i = 0; i < 5; i++) begin
            check32("t4_hold_valid", 32'(rsp_valid_o), 32'd1);
            check32("t4_hold_data", rsp_data_o, 32'd1);
            check32("t4_hold_busy", 32'(busy_o), 32'd1);
            check32("t4_hold_no_ready", 32'(req_ready_o), 32'd0);
            @(negedge clk);
        end
        tick();
        rsp_ready_i = 2'b11;
        @(negedge clk);
        check32("t4_resp_cycle_no_ready", 32'(req_ready_o), 32'd0);
        @(negedge clk);
        check32("t4_p1_next_idle", 32'(req_ready_o), 32'd2);
        tick();
        req_valid_i = '0;
        wait_idle();

        // Reset during EXEC drops the op and restores port-0 priority.
        tick();
        set_req(0, ALU_OP_ADD, 32'd1, 32'd2);
        wait_accept(0);
        tick();
        req_valid_i = '0;
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check32("t5_no_rsp", 32'(rsp_valid_o), 32'd0);
            check32("t5_idle", 32'(busy_o), 32'd0);
        end
        tick();
        set_req(0, ALU_OP_AND, 32'h0000_F0F0, 32'h0000_FF00);
        set_req(1, ALU_OP_OR, 32'h0000_000F, 32'h0000_00F0);
        push_exp(1'b0, 32'h0000_F000);
        push_exp(1'b1, 32'h0000_00FF);
        @(negedge clk);
        check32("t5_first_grant", 32'(req_ready_o), 32'd1);
        tick();
        req_valid_i[0] = 1'b0;
        wait_accept(1);
        tick();
        req_valid_i = '0;
        wait_idle();

`ifdef JEDRO_1_ALU_ARB_STATS_EN
        pulse_reset();
        run_op(0, ALU_OP_ADD, 32'd1, 32'd1, 32'd2);
        run_op(1, ALU_OP_SLL, 32'd1, 32'd4, 32'd16);
        run_op(0, ALU_OP_SRL, 32'h0000_0100, 32'd4, 32'h0000_0010);
        run_op(1, ALU_OP_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd1);
        run_op(0, 4'b1111, 32'd9, 32'd9, 32'd0);
        check32("stats_cnt0", grant_cnt0_o, 32'd3);
        check32("stats_cnt1", grant_cnt1_o, 32'd2);
        pulse_reset();
        @(negedge clk);
        check32("stats_cnt0_rst", grant_cnt0_o, 32'd0);
        check32("stats_cnt1_rst", grant_cnt1_o, 32'd0);
`endif

        wait_idle();
        check32("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
